// File: rtl/pio_input_edge_irq.sv
// Avalon-MM parallel input port: two-flop synchroniser, optional tick-based debounce,
// sticky write-1-to-clear edge capture and a maskable level interrupt.
module pio_input_edge_irq #(
    parameter int          WIDTH          = 8,
    parameter int          EDGE_TYPE      = 0,
    parameter int          DEBOUNCE_W     = 16,
    parameter int unsigned DEBOUNCE_RESET = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [DEBOUNCE_W-1:0] PERIOD_RST = DEBOUNCE_RESET[DEBOUNCE_W-1:0];

    logic [WIDTH-1:0]      sync1_q, sync2_q, sample_q, stable_q, stable_dly_q;
    logic [WIDTH-1:0]      edgecap_q, irqmask_q;
    logic [DEBOUNCE_W-1:0] period_q, count_q;
    logic [31:0]           readdata_q;

    logic [WIDTH-1:0]      sample_d, stable_d, edgecap_d, irqmask_d;
    logic [WIDTH-1:0]      event_s, clear_s;
    logic [DEBOUNCE_W-1:0] period_d, count_d;
    logic [31:0]           readdata_d;
    logic                  wr_s, wr_mask_s, wr_edge_s, wr_period_s, tick_s;
    logic                  unused_wdata_s;

    // Per-bit edge event selected by the EDGE_TYPE parameter
    function automatic logic [WIDTH-1:0] edge_event(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] prev);
        logic [WIDTH-1:0] ev;
        case (EDGE_TYPE)
            32'sd0:  ev = cur & ~prev;
            32'sd1:  ev = ~cur & prev;
            default: ev = cur ^ prev;
        endcase
        return ev;
    endfunction

    assign wr_s           = chipselect & ~write_n;
    assign wr_mask_s      = wr_s & (address == 2'd1);
    assign wr_edge_s      = wr_s & (address == 2'd2);
    assign wr_period_s    = wr_s & (address == 2'd3);
    assign tick_s         = (period_q != '0) && (count_q == period_q);
    assign event_s        = edge_event(stable_q, stable_dly_q);
    assign unused_wdata_s = ^writedata;

    // Prescaler: counts 0..period, restarts on a PERIOD write, idles at 0 in bypass
    always_comb begin
        count_d = count_q;
        if (wr_period_s) begin
            count_d = '0;
        end else if ((period_q == '0) || tick_s) begin
            count_d = '0;
        end else begin
            count_d = count_q + DEBOUNCE_W'(1'b1);
        end
    end

    // Debounce: a bit only moves when two consecutive tick samples agree
    always_comb begin
        sample_d = sample_q;
        stable_d = stable_q;
        if (period_q == '0) begin
            stable_d = sync2_q;
        end else if (tick_s) begin
            sample_d = sync2_q;
            stable_d = (stable_q & (sync2_q ^ sample_q)) | (sync2_q & ~(sync2_q ^ sample_q));
        end else begin
            sample_d = sample_q;
        end
    end

    // Register-file next state; a capture event beats a same-cycle clear
    always_comb begin
        clear_s   = '0;
        irqmask_d = irqmask_q;
        period_d  = period_q;
        if (wr_edge_s) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = '0;
        end
        if (wr_mask_s) begin
            irqmask_d = writedata[WIDTH-1:0];
        end else begin
            irqmask_d = irqmask_q;
        end
        if (wr_period_s) begin
            period_d = writedata[DEBOUNCE_W-1:0];
        end else begin
            period_d = period_q;
        end
        edgecap_d = (edgecap_q & ~clear_s) | event_s;
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0]      = stable_q;
            2'd1:    readdata_d[WIDTH-1:0]      = irqmask_q;
            2'd2:    readdata_d[WIDTH-1:0]      = edgecap_q;
            2'd3:    readdata_d[DEBOUNCE_W-1:0] = period_q;
            default: readdata_d                 = 32'd0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sample_q     <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            edgecap_q    <= '0;
            irqmask_q    <= '0;
            period_q     <= PERIOD_RST;
            count_q      <= '0;
            readdata_q   <= 32'd0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            sample_q     <= sample_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edgecap_q    <= edgecap_d;
            irqmask_q    <= irqmask_d;
            period_q     <= period_d;
            count_q      <= count_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Bench for pio_input_edge_irq: an 8-bit rising-edge instance and a 4-bit any-edge
// instance share one bus and are checked every cycle against a behavioural model.
module tb_pio_input_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in0 = 8'h00;
    logic [3:0]  in1 = 4'h0;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] v0, v1;

    always #5 clk = ~clk;

    pio_input_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_W(16), .DEBOUNCE_RESET(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

    pio_input_edge_irq #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_W(16), .DEBOUNCE_RESET(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

    // Behavioural model state, one slot per instance
    logic [31:0] m_h1[2], m_h2[2], m_samp[2], m_stab[2], m_prev[2];
    logic [31:0] m_cap[2], m_mask[2], m_per[2], m_rd[2];
    int          m_since[2];
    logic [31:0] wmask[2];
    int          etype[2];

    initial begin
        wmask[0] = 32'h0000_00FF; wmask[1] = 32'h0000_000F;
        etype[0] = 0;             etype[1] = 2;
    end

    function automatic logic [31:0] f_in(input int d);
        return (d == 0) ? {24'd0, in0} : {28'd0, in1};
    endfunction

    // A tick falls on every (P+1)-th edge counted from reset or the last PERIOD write
    function automatic bit f_tick(input int d);
        int p;
        p = int'(m_per[d]);
        return (p != 0) && (((m_since[d] + 1) % (p + 1)) == 0);
    endfunction

    function automatic logic [31:0] f_stab(input int d);
        logic [31:0] r;
        r = m_stab[d];
        if (m_per[d] == 32'd0) r = m_h2[d];
        else if (f_tick(d))
            for (int i = 0; i < 32; i++)
                if (m_h2[d][i] == m_samp[d][i]) r[i] = m_h2[d][i];
        return r;
    endfunction

    function automatic logic [31:0] f_event(input int d);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (etype[d] == 0)      r[i] = m_stab[d][i] && !m_prev[d][i];
            else if (etype[d] == 1) r[i] = !m_stab[d][i] && m_prev[d][i];
            else                    r[i] = m_stab[d][i] != m_prev[d][i];
        end
        return r;
    endfunction

    function automatic logic [31:0] f_reg(input int d, input logic [1:0] a);
        case (a)
            2'd0:    return m_stab[d];
            2'd1:    return m_mask[d];
            2'd2:    return m_cap[d];
            default: return m_per[d];
        endcase
    endfunction

    function automatic bit f_wr(input logic [1:0] a);
        return chipselect && !write_n && (address == a);
    endfunction

    // Model update on each clock edge, cleared asynchronously with the DUT
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_h1[d] <= 32'd0; m_h2[d] <= 32'd0; m_samp[d] <= 32'd0;
                m_stab[d] <= 32'd0; m_prev[d] <= 32'd0; m_cap[d] <= 32'd0;
                m_mask[d] <= 32'd0; m_per[d] <= 32'd0; m_rd[d] <= 32'd0;
                m_since[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_h1[d]   <= f_in(d);
                m_h2[d]   <= m_h1[d];
                m_samp[d] <= f_tick(d) ? m_h2[d] : m_samp[d];
                m_stab[d] <= f_stab(d);
                m_prev[d] <= m_stab[d];
                m_cap[d]  <= ((m_cap[d] & ~(f_wr(2'd2) ? writedata : 32'd0)) | f_event(d)) & wmask[d];
                m_mask[d] <= f_wr(2'd1) ? (writedata & wmask[d]) : m_mask[d];
                m_per[d]  <= f_wr(2'd3) ? (writedata & 32'h0000_FFFF) : m_per[d];
                m_since[d] <= f_wr(2'd3) ? 0 : m_since[d] + 1;
                m_rd[d]   <= f_reg(d, address);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_rd0", rd0, 32'd0);
            check("rst_irq0", {31'd0, irq0}, 32'd0);
            check("rst_rd1", rd1, 32'd0);
            check("rst_irq1", {31'd0, irq1}, 32'd0);
        end else begin
            check("model_rd0", rd0, m_rd[0]);
            check("model_irq0", {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
            check("model_rd1", rd1, m_rd[1]);
            check("model_irq1", {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
        address = a;
        @(negedge clk);
        r0 = rd0; r1 = rd1;
    endtask

    initial begin
        // Reset with inputs already high: DATA appears 4 edges after release
        in0 = 8'hA5; in1 = 4'h0; address = 2'd0;
        idle(3);
        check("hold_rst_rd", rd0, 32'd0);
        reset_n = 1'b1;
        idle(4);
        check("reset_data", rd0, 32'h0000_00A5);

        // Rising capture with exact 4-cycle latency, then W1C clear
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h01);
        in0 = 8'hA4;
        idle(6);
        wr(2'd2, 32'hFF);
        in0 = 8'hA5;
        idle(3);
        check("irq_lat3", {31'd0, irq0}, 32'd0);
        idle(1);
        check("irq_lat4", {31'd0, irq0}, 32'd1);
        rd(2'd2, v0, v1);
        check("cap_bit0", v0, 32'h01);
        wr(2'd2, 32'h01);
        check("irq_clr", {31'd0, irq0}, 32'd0);

        // Clear and capture on the same bit in the same cycle
        wr(2'd1, 32'h02);
        in0 = 8'hA7;
        idle(6);
        check("irq_bit1", {31'd0, irq0}, 32'd1);
        in0 = 8'hA5;
        idle(6);
        in0 = 8'hA7;
        idle(2);
        wr(2'd2, 32'h02);
        check("simul_irq", {31'd0, irq0}, 32'd1);
        rd(2'd2, v0, v1);
        check("simul_cap", v0, 32'h02);

        // Debounce with PERIOD=3: short glitch rejected, long hold accepted
        in0 = 8'hA1;
        wr(2'd3, 32'd3);
        idle(14);
        wr(2'd2, 32'hFF);
        in0 = 8'hA5;
        idle(2);
        in0 = 8'hA1;
        idle(14);
        rd(2'd0, v0, v1);
        check("db_glitch_data", v0, 32'hA1);
        rd(2'd2, v0, v1);
        check("db_glitch_cap", v0, 32'h00);
        in0 = 8'hA5;
        idle(11);
        rd(2'd0, v0, v1);
        check("db_hold_data", v0, 32'hA5);
        rd(2'd2, v0, v1);
        check("db_hold_cap", v0, 32'h04);

        // Any-edge instance: masked capture, unmask, read-only DATA
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'hFF);
        in1 = 4'h8;
        idle(1);
        in1 = 4'h0;
        idle(6);
        rd(2'd2, v0, v1);
        check("any_cap", v1, 32'h8);
        check("any_masked", {31'd0, irq1}, 32'd0);
        wr(2'd1, 32'hFF8);
        check("any_irq", {31'd0, irq1}, 32'd1);
        wr(2'd0, 32'hFF);
        rd(2'd0, v0, v1);
        check("data_ro", v1, 32'h0);
        rd(2'd1, v0, v1);
        check("mask_width", v1, 32'h8);

        // Asynchronous reset in the middle of a debounce count
        wr(2'd1, 32'hFF);
        wr(2'd3, 32'd5);
        in0 = 8'h00;
        idle(20);
        wr(2'd2, 32'hFF);
        in0 = 8'hFF;
        idle(25);
        rd(2'd2, v0, v1);
        check("pre_rst_cap", v0, 32'hFF);
        check("pre_rst_irq", {31'd0, irq0}, 32'd1);
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rd", rd0, 32'd0);
        check("async_irq", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, v0, v1);
        check("post_rst_cap", v0, 32'h0);
        rd(2'd3, v0, v1);
        check("post_rst_period", v0, 32'h0);
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
